// File: rtl/router_pkg.sv
// ============================================================================
// Module  : router_pkg
// Brief   : Shared router defaults and the per-channel timeout state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int ROUTER_NUM_CH   = 3;
    localparam int ROUTER_AW       = 2;
    localparam int ROUTER_TIMEOUT  = 30;

    typedef enum logic [0:0] {
        TMR_COUNT = 1'b0,
        TMR_FLUSH = 1'b1
    } tmr_state_e;

endpackage : router_pkg

`default_nettype wire

// File: rtl/router_sync_timer.sv
// ============================================================================
// Module  : router_sync_timer
// Brief   : Per-channel stall timer; pulses soft_rst for one cycle on timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic rd_en,
    output logic soft_rst
);

    localparam int TW = $clog2(TIMEOUT + 1);

    tmr_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TMR_COUNT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Any read or an empty FIFO restarts the count; the flush cycle ignores rd_en.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            TMR_COUNT: begin
                if (valid && !rd_en) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = TMR_FLUSH;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            TMR_FLUSH: begin
                state_d = TMR_COUNT;
                timer_d = '0;
            end
            default: begin
                state_d = TMR_COUNT;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        soft_rst = (state_q == TMR_FLUSH);
    end

endmodule : router_sync_timer

`default_nettype wire

// File: rtl/router_sync_nch.sv
// ============================================================================
// Module  : router_sync_nch
// Brief   : N-channel router synchronizer: address latch, write steering,
//           full-flag mux, valid flags and per-channel stall soft resets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_sync_nch
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int AW      = ROUTER_AW,
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              det_addr,
    input  logic [AW-1:0]     din,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] valid_out,
    output logic [NUM_CH-1:0] soft_rst,
    output logic              addr_err
);

    logic [AW-1:0] addr_q;
    logic          addr_vld_q;
    logic          addr_err_q;
    logic          din_in_range;

    assign din_in_range = (int'(din) < NUM_CH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= det_addr && !din_in_range;
            if (det_addr) begin
                addr_q     <= din;
                addr_vld_q <= din_in_range;
            end
        end
    end

    // A bad address leaves addr_vld low, which suppresses both writes and the full flag.
    always_comb begin
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_vld_q && (addr_q == AW'(i))) begin
                wr_en[i]  = wr_en_reg;
                fifo_full = full[i];
            end
        end
    end

    assign valid_out = ~empty;
    assign addr_err  = addr_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .valid    (valid_out[g]),
            .rd_en    (rd_en[g]),
            .soft_rst (soft_rst[g])
        );
    end

endmodule : router_sync_nch

`default_nettype wire
